// File: rtl/mem_port_arbiter_pkg.sv
// Shared constants for the fetch/data memory port arbiter: FSM encodings,
// requester identifiers and the latency counter width.
package mem_port_arbiter_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;

  localparam logic REQ_IF = 1'b0;
  localparam logic REQ_D  = 1'b1;

  localparam int unsigned CNT_W = 4;

endpackage

// File: rtl/mem_port_arbiter_arb_pick.sv
// Combinational winner select between fetch and data requesters.
// MEM_ARB_RR_EN selects round-robin on contention; default is data-over-fetch priority.
module arb_pick
  import mem_port_arbiter_pkg::*;
(
  input  logic if_req,
  input  logic d_req,
  input  logic last_winner,
  output logic gnt_if,
  output logic gnt_d
);

`ifdef MEM_ARB_RR_EN
  // On contention the side that did not win last time goes first.
  always_comb begin
    gnt_if = if_req;
    gnt_d  = d_req;
    if (if_req && d_req) begin
      gnt_d  = (last_winner == REQ_IF);
      gnt_if = (last_winner == REQ_D);
    end
  end
`else
  logic unused_last_winner;
  assign unused_last_winner = last_winner;

  always_comb begin
    gnt_d  = d_req;
    gnt_if = if_req && !d_req;
  end
`endif

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one synchronous single-ported memory between instruction fetch and data ports.
// Optional round-robin arbitration via `define MEM_ARB_RR_EN (see arb_pick).
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned MEM_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  logic [1:0]        state, state_d;
  logic [CNT_W-1:0]  cnt, cnt_d;
  logic              owner, owner_d;
  logic              we_d;
  logic [ADDR_W-1:0] addr_d;
  logic [DATA_W-1:0] wdata_d;
  logic              pick_if, pick_d;

  arb_pick u_pick (
    .if_req      (if_req),
    .d_req       (d_req),
    .last_winner (owner),
    .gnt_if      (pick_if),
    .gnt_d       (pick_d)
  );

  // Grants are only offered in IDLE and are suppressed while reset is held.
  assign if_gnt = pick_if && (state == ST_IDLE) && !rst;
  assign d_gnt  = pick_d  && (state == ST_IDLE) && !rst;

  // Read data passes straight from memory in the completion cycle; stores return 0.
  assign if_rdata = if_rvalid ? mem_rdata : '0;
  assign d_rdata  = (d_rvalid && !mem_we) ? mem_rdata : '0;

  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    owner_d = owner;
    we_d    = mem_we;
    addr_d  = mem_addr;
    wdata_d = mem_wdata;
    case (state)
      ST_IDLE: begin
        if (d_gnt) begin
          owner_d = REQ_D;
          we_d    = d_we;
          addr_d  = d_addr;
          wdata_d = d_wdata;
          state_d = ST_ISSUE;
        end else if (if_gnt) begin
          owner_d = REQ_IF;
          we_d    = 1'b0;
          addr_d  = if_addr;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        cnt_d   = CNT_W'(MEM_LAT);
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        cnt_d = cnt - CNT_W'(1);
        if (cnt == CNT_W'(1)) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs are registered from next-state values so they line up with the state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      owner     <= REQ_IF;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      busy      <= 1'b0;
      if_rvalid <= 1'b0;
      d_rvalid  <= 1'b0;
    end else begin
      state     <= state_d;
      cnt       <= cnt_d;
      owner     <= owner_d;
      mem_en    <= (state_d == ST_ISSUE);
      mem_we    <= we_d;
      mem_addr  <= addr_d;
      mem_wdata <= wdata_d;
      busy      <= (state_d != ST_IDLE);
      if_rvalid <= (state_d == ST_WAIT) && (cnt_d == CNT_W'(1)) && (owner_d == REQ_IF);
      d_rvalid  <= (state_d == ST_WAIT) && (cnt_d == CNT_W'(1)) && (owner_d == REQ_D);
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: one MEM_LAT=1 instance and one MEM_LAT=3 instance,
// each driven by a small synchronous memory model.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req, d_req, d_we;
  logic [31:0] if_addr, d_addr, d_wdata;
  logic        if_gnt, if_rvalid, d_gnt, d_rvalid, mem_en, mem_we, busy;
  logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata, mem_rdata;

  logic        if_req3;
  logic [31:0] if_addr3;
  logic        if_gnt3, if_rvalid3, d_gnt3, d_rvalid3, mem_en3, mem_we3, busy3;
  logic [31:0] if_rdata3, d_rdata3, mem_addr3, mem_wdata3, mem_rdata3;

  logic [31:0] mem [0:255];
  logic [31:0] rd1, p0, p1, p2;
  int          n_checks = 0;
  int          n_fails  = 0;
  logic        exp_d;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1)) u_dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(3)) u_dut3 (
    .clk(clk), .rst(rst),
    .if_req(if_req3), .if_addr(if_addr3), .if_gnt(if_gnt3), .if_rvalid(if_rvalid3), .if_rdata(if_rdata3),
    .d_req(1'b0), .d_we(1'b0), .d_addr(32'h0), .d_wdata(32'h0),
    .d_gnt(d_gnt3), .d_rvalid(d_rvalid3), .d_rdata(d_rdata3),
    .mem_en(mem_en3), .mem_we(mem_we3), .mem_addr(mem_addr3), .mem_wdata(mem_wdata3),
    .mem_rdata(mem_rdata3), .busy(busy3)
  );

  // Memory shared by both instances; only the MEM_LAT=1 instance stores. Data is only
  // valid exactly MEM_LAT cycles after mem_en, otherwise a marker value.
  always @(posedge clk) begin
    rd1 <= 32'hBAD0BAD0;
    p0  <= 32'hBAD0BAD0;
    p1  <= p0;
    p2  <= p1;
    if (rst) begin
      mem[16] <= 32'h2002000A;
      mem[17] <= 32'h8C220004;
    end else if (mem_en && mem_we) begin
      mem[mem_addr[9:2]] <= mem_wdata;
    end
    if (mem_en && !mem_we) rd1 <= mem[mem_addr[9:2]];
    if (mem_en3) p0 <= mem[mem_addr3[9:2]];
  end
  assign mem_rdata  = rd1;
  assign mem_rdata3 = p2;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; if_req = 1'b1; d_req = 1'b1; d_we = 1'b0;
    if_addr = 32'h0; d_addr = 32'h0; d_wdata = 32'h0;
    if_req3 = 1'b0; if_addr3 = 32'h0;
    tick(); tick();
    check("rst_if_gnt", 32'(if_gnt), 0);
    check("rst_d_gnt", 32'(d_gnt), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_mem_en", 32'(mem_en), 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_if_rvalid", 32'(if_rvalid), 0);
    check("rst_d_rdata", d_rdata, 0);
    if_req = 1'b0; d_req = 1'b0; rst = 1'b0;
    tick();

    // Store 0xDEADBEEF to 0x100
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h100; d_wdata = 32'hDEADBEEF; #1;
    check("st_d_gnt", 32'(d_gnt), 1);
    check("st_if_gnt", 32'(if_gnt), 0);
    tick(); d_req = 1'b0; d_we = 1'b0; #1;
    check("st_mem_en", 32'(mem_en), 1);
    check("st_mem_we", 32'(mem_we), 1);
    check("st_mem_addr", mem_addr, 32'h100);
    check("st_mem_wdata", mem_wdata, 32'hDEADBEEF);
    tick();
    check("st_d_rvalid", 32'(d_rvalid), 1);
    check("st_d_rdata", d_rdata, 0);
    check("st_if_rvalid", 32'(if_rvalid), 0);
    tick();
    check("st_busy_done", 32'(busy), 0);
    check("st_mem_en_off", 32'(mem_en), 0);
    check("st_wdata_hold", mem_wdata, 32'hDEADBEEF);

    // Load back from 0x100
    d_req = 1'b1; d_addr = 32'h100; #1;
    check("ld_d_gnt", 32'(d_gnt), 1);
    tick(); d_req = 1'b0;
    tick();
    check("ld_d_rvalid", 32'(d_rvalid), 1);
    check("ld_d_rdata", d_rdata, 32'hDEADBEEF);
    check("ld_if_rdata", if_rdata, 0);
    tick();

    // Fetch from 0x40
    if_req = 1'b1; if_addr = 32'h40; #1;
    check("f_if_gnt", 32'(if_gnt), 1);
    check("f_busy_idle", 32'(busy), 0);
    tick(); if_req = 1'b0;
    check("f_mem_en", 32'(mem_en), 1);
    check("f_mem_addr", mem_addr, 32'h40);
    check("f_mem_we", 32'(mem_we), 0);
    check("f_busy", 32'(busy), 1);
    tick();
    check("f_if_rvalid", 32'(if_rvalid), 1);
    check("f_if_rdata", if_rdata, 32'h2002000A);
    check("f_d_rvalid", 32'(d_rvalid), 0);
    check("f_d_rdata", d_rdata, 0);
    tick();
    check("f_busy_done", 32'(busy), 0);
    check("f_if_rvalid_off", 32'(if_rvalid), 0);

    // Contention after a fetch: data wins in both arbitration modes
    if_req = 1'b1; if_addr = 32'h44; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h100; #1;
    check("c_d_gnt", 32'(d_gnt), 1);
    check("c_if_gnt", 32'(if_gnt), 0);
    tick(); d_req = 1'b0; #1;
    check("c_if_gnt_issue", 32'(if_gnt), 0);
    check("c_mem_addr_d", mem_addr, 32'h100);
    tick();
    check("c_d_rdata", d_rdata, 32'hDEADBEEF);
    check("c_if_gnt_wait", 32'(if_gnt), 0);
    tick();
    check("c_if_gnt_late", 32'(if_gnt), 1);
    tick(); if_req = 1'b0;
    check("c_mem_addr_if", mem_addr, 32'h44);
    tick();
    check("c_if_rdata", if_rdata, 32'h8C220004);
    tick();

    // Both requests held for six transactions
    if_addr = 32'h40; d_addr = 32'h100; d_we = 1'b0; if_req = 1'b1; d_req = 1'b1;
    for (int k = 0; k < 6; k++) begin
      #1;
`ifdef MEM_ARB_RR_EN
      exp_d = (k % 2 == 0);
`else
      exp_d = 1'b1;
`endif
      check($sformatf("h_d_gnt%0d", k), 32'(d_gnt), 32'(exp_d));
      check($sformatf("h_if_gnt%0d", k), 32'(if_gnt), 32'(!exp_d));
      tick();
      check($sformatf("h_addr%0d", k), mem_addr, exp_d ? 32'h100 : 32'h40);
      tick(); tick();
    end
    if_req = 1'b0; d_req = 1'b0;

    // MEM_LAT=3 instance
    if_req3 = 1'b1; if_addr3 = 32'h40; #1;
    check("l3_gnt", 32'(if_gnt3), 1);
    tick();
    check("l3_mem_en", 32'(mem_en3), 1);
    check("l3_mem_addr", mem_addr3, 32'h40);
    tick();
    check("l3_rvalid_n2", 32'(if_rvalid3), 0);
    check("l3_busy", 32'(busy3), 1);
    tick();
    check("l3_rvalid_n3", 32'(if_rvalid3), 0);
    tick();
    check("l3_rvalid_n4", 32'(if_rvalid3), 1);
    check("l3_rdata", if_rdata3, 32'h2002000A);
    check("l3_gnt_n4", 32'(if_gnt3), 0);
    tick();
    check("l3_gnt_n5", 32'(if_gnt3), 1);

    // Reset while the second transaction is in WAIT
    tick(); if_req3 = 1'b0;
    tick();
    check("r_busy_pre", 32'(busy3), 1);
    rst = 1'b1; if_req3 = 1'b1; if_req = 1'b1; #1;
    check("r_busy", 32'(busy3), 0);
    check("r_mem_en", 32'(mem_en3), 0);
    check("r_mem_addr", mem_addr3, 0);
    check("r_if_gnt3", 32'(if_gnt3), 0);
    check("r_if_gnt", 32'(if_gnt), 0);
    tick();
    if_req3 = 1'b0; if_req = 1'b0; rst = 1'b0;
    tick();
    check("r_no_rvalid_n4", 32'(if_rvalid3), 0);
    check("r_no_rdata_n4", if_rdata3, 0);
    tick();
    check("r_no_rvalid_n5", 32'(if_rvalid3), 0);
    check("r_busy_after", 32'(busy3), 0);
    if_req3 = 1'b1; if_addr3 = 32'h44; #1;
    check("r_new_gnt", 32'(if_gnt3), 1);
    tick(); if_req3 = 1'b0;
    check("r_new_addr", mem_addr3, 32'h44);
    tick(); tick(); tick();
    check("r_new_rvalid", 32'(if_rvalid3), 1);
    check("r_new_rdata", if_rdata3, 32'h8C220004);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
